// File: rtl/mod_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined modular multiplier between NB_REQ
// requesters. A tag FIFO remembers who issued each operation so results are
// returned to their owner in issue order.

package mod_mult_pkg;
  // Flavours of the shared modular multiplier; UNKNOWN marks an unconfigured build.
  typedef enum logic [1:0] {
    MOD_MULT_UNKNOWN    = 2'd0,
    MOD_MULT_GOLDILOCKS = 2'd1,
    MOD_MULT_SOLINAS    = 2'd2,
    MOD_MULT_MONTGOMERY = 2'd3
  } mod_mult_type_e;
endpackage

module mod_mult_arbiter
  import mod_mult_pkg::*;
#(
  parameter int unsigned    NB_REQ        = 4,
  parameter int unsigned    MOD_W         = 64,
  parameter mod_mult_type_e MOD_MULT_TYPE = MOD_MULT_GOLDILOCKS,
  parameter int unsigned    TAG_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            a_rst_n,
  input  logic [NB_REQ-1:0]               req_vld,
  output logic [NB_REQ-1:0]               req_rdy,
  input  logic [NB_REQ*MOD_W-1:0]         req_a,
  input  logic [NB_REQ*MOD_W-1:0]         req_b,
  output logic [MOD_W-1:0]                mult_a,
  output logic [MOD_W-1:0]                mult_b,
  output logic                            mult_avail,
  input  logic [MOD_W-1:0]                mult_z,
  input  logic                            mult_z_avail,
  output logic [MOD_W-1:0]                rsp_z,
  output logic [NB_REQ-1:0]               rsp_avail,
  output logic [$clog2(TAG_DEPTH+1)-1:0]  in_flight,
  output logic                            error_underflow
);

  localparam int unsigned IDX_W = $clog2(NB_REQ);
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  // Reject configurations the datapath cannot support.
  if (MOD_MULT_TYPE == MOD_MULT_UNKNOWN) begin : g_chk_type
    $fatal(1, "mod_mult_arbiter: MOD_MULT_TYPE must name an attached multiplier");
  end
  if ((NB_REQ < 2) || (NB_REQ > 16)) begin : g_chk_nb_req
    $fatal(1, "mod_mult_arbiter: NB_REQ must be in 2..16");
  end
  if ((TAG_DEPTH < 2) || ((TAG_DEPTH & (TAG_DEPTH - 1)) != 0)) begin : g_chk_depth
    $fatal(1, "mod_mult_arbiter: TAG_DEPTH must be a power of 2, at least 2");
  end

  // Arbitration state and issue-side signals.
  logic [IDX_W-1:0] last_gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             gnt_found;
  logic             fifo_full;
  logic             push;
  logic [MOD_W-1:0] gnt_a;
  logic [MOD_W-1:0] gnt_b;

  // Tag FIFO and return-side signals.
  logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] head_tag;
  logic             pop;
  logic             underflow;
  logic [NB_REQ-1:0] rsp_hit;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_idx   = last_gnt;
    gnt_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= int'(NB_REQ); k++) begin
      cand = IDX_W'((32'(last_gnt) + 32'(k)) % NB_REQ);
      if (!gnt_found && req_vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Full is judged on the registered count, so a same-cycle pop frees nothing.
  always_comb begin
    fifo_full = (in_flight >= FULL_CNT);
    push      = a_rst_n & gnt_found & ~fifo_full;
  end

  // One-hot grant; held at zero while reset is asserted.
  always_comb begin
    req_rdy = '0;
    if (push) begin
      req_rdy[gnt_idx] = 1'b1;
    end
  end

  // Select the granted requester's operand slices.
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < int'(NB_REQ); i++) begin
      if (IDX_W'(i) == gnt_idx) begin
        gnt_a = req_a[i*MOD_W +: MOD_W];
        gnt_b = req_b[i*MOD_W +: MOD_W];
      end
    end
  end

  // Result classification and one-hot decode of the FIFO head tag.
  always_comb begin
    head_tag  = tag_mem[rd_ptr];
    pop       = mult_z_avail & (in_flight != '0);
    underflow = mult_z_avail & (in_flight == '0);
    rsp_hit   = '0;
    for (int i = 0; i < int'(NB_REQ); i++) begin
      rsp_hit[i] = pop & (head_tag == IDX_W'(i));
    end
  end

  // Issue stage: remember the winner and register its operands.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      last_gnt   <= IDX_W'(NB_REQ - 1);
      mult_a     <= '0;
      mult_b     <= '0;
      mult_avail <= 1'b0;
    end else begin
      mult_avail <= push;
      if (push) begin
        last_gnt <= gnt_idx;
        mult_a   <= gnt_a;
        mult_b   <= gnt_b;
      end
    end
  end

  // Tag FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int i = 0; i < int'(TAG_DEPTH); i++) begin
        tag_mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_flight <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= gnt_idx;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Return stage: route the result to its owner, flag orphan results.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      rsp_z           <= '0;
      rsp_avail       <= '0;
      error_underflow <= 1'b0;
    end else begin
      rsp_avail <= rsp_hit;
      if (pop) begin
        rsp_z <= mult_z;
      end
      if (underflow) begin
        error_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_mult_arbiter.sv
// Directed bench for mod_mult_arbiter: two instances (depth 8 with a 5-stage
// model multiplier, depth 4 with an 8-stage one) driven from one initial block.

module tb_mod_mult_arbiter;
  import mod_mult_pkg::*;

  localparam logic [127:0] P = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_vld;
  logic [3:0]   req_vld4;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic         inj_vld;
  logic [63:0]  inj_z;

  logic [3:0]  req_rdy, rsp_avail;
  logic [63:0] mult_a, mult_b, mult_z, rsp_z;
  logic        mult_avail, mult_z_avail, err;
  logic [3:0]  in_flight;

  logic [3:0]  req_rdy4, rsp_avail4;
  logic [63:0] mult_a4, mult_b4, mult_z4, rsp_z4;
  logic        mult_avail4, mult_z_avail4, err4;
  logic [2:0]  in_flight4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] gold(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] t;
    t = 128'(a) * 128'(b);
    return 64'(t % P);
  endfunction

  // Model multipliers: fixed-latency shift registers of Goldilocks products.
  logic [4:0]  p8_v;
  logic [63:0] p8_z [5];
  logic [7:0]  p4_v;
  logic [63:0] p4_z [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p8_v <= '0;
      p4_v <= '0;
    end else begin
      p8_v    <= {p8_v[3:0], mult_avail};
      p8_z[0] <= gold(mult_a, mult_b);
      for (int i = 1; i < 5; i++) p8_z[i] <= p8_z[i-1];
      p4_v    <= {p4_v[6:0], mult_avail4};
      p4_z[0] <= gold(mult_a4, mult_b4);
      for (int i = 1; i < 8; i++) p4_z[i] <= p4_z[i-1];
    end
  end

  assign mult_z_avail  = p8_v[4] | inj_vld;
  assign mult_z        = inj_vld ? inj_z : p8_z[4];
  assign mult_z_avail4 = p4_v[7];
  assign mult_z4       = p4_z[7];

  mod_mult_arbiter #(
    .NB_REQ(4), .MOD_W(64), .MOD_MULT_TYPE(MOD_MULT_GOLDILOCKS), .TAG_DEPTH(8)
  ) u_dut (
    .clk(clk), .a_rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .mult_a(mult_a), .mult_b(mult_b),
    .mult_avail(mult_avail), .mult_z(mult_z), .mult_z_avail(mult_z_avail),
    .rsp_z(rsp_z), .rsp_avail(rsp_avail), .in_flight(in_flight),
    .error_underflow(err)
  );

  mod_mult_arbiter #(
    .NB_REQ(4), .MOD_W(64), .MOD_MULT_TYPE(MOD_MULT_GOLDILOCKS), .TAG_DEPTH(4)
  ) u_dut4 (
    .clk(clk), .a_rst_n(rst_n), .req_vld(req_vld4), .req_rdy(req_rdy4),
    .req_a(req_a), .req_b(req_b), .mult_a(mult_a4), .mult_b(mult_b4),
    .mult_avail(mult_avail4), .mult_z(mult_z4), .mult_z_avail(mult_z_avail4),
    .rsp_z(rsp_z4), .rsp_avail(rsp_avail4), .in_flight(in_flight4),
    .error_underflow(err4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    req_vld  = '0;
    req_vld4 = '0;
    inj_vld  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; req_vld = 4'hF; req_vld4 = '0; inj_vld = 1'b0; inj_z = '0;
    req_a = '0; req_b = '0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL reset_rdy: got %b want 0000", req_rdy); end
    total++; if (mult_avail !== 1'b0) begin bad++; $display("FAIL reset_mult_avail: got %b want 0", mult_avail); end
    total++; if (mult_a !== 64'd0) begin bad++; $display("FAIL reset_mult_a: got %0d want 0", mult_a); end
    total++; if (rsp_avail !== 4'b0000) begin bad++; $display("FAIL reset_rsp_avail: got %b want 0000", rsp_avail); end
    total++; if (rsp_z !== 64'd0) begin bad++; $display("FAIL reset_rsp_z: got %0d want 0", rsp_z); end
    total++; if (in_flight !== 4'd0) begin bad++; $display("FAIL reset_in_flight: got %0d want 0", in_flight); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    repeat (2) tick();
    req_vld = '0;
    rst_n   = 1'b1;
  endtask

  task automatic test_single;
    set_ops(2, 64'd3, 64'd5);
    req_vld = 4'b0100;
    #1;
    total++; if (req_rdy !== 4'b0100) begin bad++; $display("FAIL single_rdy: got %b want 0100", req_rdy); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      req_vld = '0;
      if (c == 1) begin
        total++; if (mult_avail !== 1'b1) begin bad++; $display("FAIL single_issue: got %b want 1", mult_avail); end
        total++; if (mult_a !== 64'd3 || mult_b !== 64'd5) begin bad++; $display("FAIL single_ops: got %0d,%0d want 3,5", mult_a, mult_b); end
        total++; if (in_flight !== 4'd1) begin bad++; $display("FAIL single_in_flight1: got %0d want 1", in_flight); end
      end
      if (c == 2) begin
        total++; if (mult_avail !== 1'b0 || mult_a !== 64'd3) begin bad++; $display("FAIL single_hold: got avail=%b a=%0d want 0,3", mult_avail, mult_a); end
      end
      if (c >= 2 && c <= 6) begin
        total++; if (rsp_avail !== 4'b0000) begin bad++; $display("FAIL single_early_rsp c=%0d: got %b want 0000", c, rsp_avail); end
      end
      if (c == 6) begin
        total++; if (in_flight !== 4'd1) begin bad++; $display("FAIL single_in_flight6: got %0d want 1", in_flight); end
      end
      if (c == 7) begin
        total++; if (rsp_avail !== 4'b0100) begin bad++; $display("FAIL single_rsp: got %b want 0100", rsp_avail); end
        total++; if (rsp_z !== 64'd15) begin bad++; $display("FAIL single_rsp_z: got %0d want 15", rsp_z); end
        total++; if (in_flight !== 4'd0) begin bad++; $display("FAIL single_drain: got %0d want 0", in_flight); end
      end
      if (c == 8) begin
        total++; if (rsp_avail !== 4'b0000) begin bad++; $display("FAIL single_rsp_pulse: got %b want 0000", rsp_avail); end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [63:0] prod [4];
    logic [3:0]  want;
    int          c;
    prod = '{64'd14, 64'd24, 64'd36, 64'd50};
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 64'(i + 2), 64'(i + 7));
    for (int t = 0; t < 20; t++) begin
      req_vld = (t < 12) ? 4'hF : 4'h0;
      #1;
      if (t < 12) begin
        want = 4'(1 << (t % 4));
        total++; if (req_rdy !== want) begin bad++; $display("FAIL rr_grant t=%0d: got %b want %b", t, req_rdy, want); end
      end
      tick();
      c = t + 1;
      total++; if (mult_avail !== (t < 12)) begin bad++; $display("FAIL rr_issue t=%0d: got %b want %b", t, mult_avail, (t < 12)); end
      if (t < 12) begin
        total++; if (mult_a !== 64'(t % 4 + 2)) begin bad++; $display("FAIL rr_op t=%0d: got %0d want %0d", t, mult_a, t % 4 + 2); end
      end
      if (c >= 7 && c < 19) begin
        want = 4'(1 << ((c - 7) % 4));
        total++; if (rsp_avail !== want) begin bad++; $display("FAIL rr_rsp c=%0d: got %b want %b", c, rsp_avail, want); end
        total++; if (rsp_z !== prod[(c - 7) % 4]) begin bad++; $display("FAIL rr_rsp_z c=%0d: got %0d want %0d", c, rsp_z, prod[(c - 7) % 4]); end
      end else begin
        total++; if (rsp_avail !== 4'b0000) begin bad++; $display("FAIL rr_idle_rsp c=%0d: got %b want 0000", c, rsp_avail); end
      end
    end
    total++; if (in_flight !== 4'd0) begin bad++; $display("FAIL rr_drain: got %0d want 0", in_flight); end
  endtask

  task automatic test_full;
    int         max_seen;
    logic [3:0] want;
    max_seen = 0;
    do_reset();
    for (int t = 0; t < 16; t++) begin
      req_vld4 = 4'hF;
      #1;
      if (int'(in_flight4) > max_seen) max_seen = int'(in_flight4);
      if (t < 4) begin
        want = 4'(1 << t);
        total++; if (req_rdy4 !== want) begin bad++; $display("FAIL full_fill t=%0d: got %b want %b", t, req_rdy4, want); end
      end
      if (t >= 4 && t <= 9) begin
        total++; if (req_rdy4 !== 4'b0000 || in_flight4 !== 3'd4) begin bad++; $display("FAIL full_stall t=%0d: got rdy=%b cnt=%0d want 0000,4", t, req_rdy4, in_flight4); end
      end
      if (t == 10) begin
        total++; if (req_rdy4 !== 4'b0001 || in_flight4 !== 3'd3) begin bad++; $display("FAIL full_resume: got rdy=%b cnt=%0d want 0001,3", req_rdy4, in_flight4); end
      end
      if (in_flight4 == 3'd4) begin
        total++; if (req_rdy4 !== 4'b0000) begin bad++; $display("FAIL full_mask t=%0d: got %b want 0000", t, req_rdy4); end
      end
      tick();
    end
    req_vld4 = '0;
    for (int k = 0; k < 40 && in_flight4 != 3'd0; k++) begin
      if (int'(in_flight4) > max_seen) max_seen = int'(in_flight4);
      tick();
    end
    total++; if (in_flight4 !== 3'd0) begin bad++; $display("FAIL full_drain: got %0d want 0", in_flight4); end
    total++; if (max_seen != 4) begin bad++; $display("FAIL full_max: got %0d want 4", max_seen); end
    total++; if (err4 !== 1'b0) begin bad++; $display("FAIL full_err: got %b want 0", err4); end
  endtask

  task automatic test_underflow;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL uf_pre: got %b want 0", err); end
    inj_z   = 64'd99;
    inj_vld = 1'b1;
    tick();
    inj_vld = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL uf_set: got %b want 1", err); end
    total++; if (in_flight !== 4'd0) begin bad++; $display("FAIL uf_cnt: got %0d want 0", in_flight); end
    for (int k = 0; k < 3; k++) begin
      total++; if (rsp_avail !== 4'b0000) begin bad++; $display("FAIL uf_rsp k=%0d: got %b want 0000", k, rsp_avail); end
      tick();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL uf_sticky k=%0d: got %b want 1", k, err); end
    end
  endtask

  task automatic test_sparse;
    logic [3:0]  exp_oh [3];
    logic [63:0] exp_z  [3];
    int          idx;
    exp_oh = '{4'b0010, 4'b1000, 4'b0001};
    exp_z  = '{64'd11, 64'd13, 64'd10};
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 64'(10 + i), 64'd1);
    req_vld = 4'b0010;
    #1;
    total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL sparse_g1: got %b want 0010", req_rdy); end
    tick();
    total++; if (mult_a !== 64'd11) begin bad++; $display("FAIL sparse_op1: got %0d want 11", mult_a); end
    req_vld = 4'b1001;
    #1;
    total++; if (req_rdy !== 4'b1000) begin bad++; $display("FAIL sparse_g3: got %b want 1000", req_rdy); end
    tick();
    total++; if (mult_a !== 64'd13) begin bad++; $display("FAIL sparse_op3: got %0d want 13", mult_a); end
    #1;
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL sparse_g0: got %b want 0001", req_rdy); end
    tick();
    req_vld = '0;
    total++; if (mult_a !== 64'd10) begin bad++; $display("FAIL sparse_op0: got %0d want 10", mult_a); end
    idx = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_avail != 4'b0000) begin
        if (idx < 3) begin
          total++; if (rsp_avail !== exp_oh[idx] || rsp_z !== exp_z[idx]) begin bad++; $display("FAIL sparse_rsp%0d: got %b/%0d want %b/%0d", idx, rsp_avail, rsp_z, exp_oh[idx], exp_z[idx]); end
        end
        idx++;
      end
      tick();
    end
    total++; if (idx != 3) begin bad++; $display("FAIL sparse_rsp_count: got %0d want 3", idx); end
  endtask

  task automatic test_reset_midflight;
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 64'(20 + i), 64'd2);
    req_vld = 4'hF;
    repeat (3) tick();
    total++; if (in_flight !== 4'd3) begin bad++; $display("FAIL mid_pre: got %0d want 3", in_flight); end
    rst_n = 1'b0;
    #1;
    total++; if (in_flight !== 4'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", in_flight); end
    total++; if (mult_avail !== 1'b0 || mult_a !== 64'd0 || mult_b !== 64'd0) begin bad++; $display("FAIL mid_issue: got %b/%0d/%0d want 0/0/0", mult_avail, mult_a, mult_b); end
    total++; if (rsp_avail !== 4'b0000 || rsp_z !== 64'd0 || err !== 1'b0) begin bad++; $display("FAIL mid_rsp: got %b/%0d/%b want 0", rsp_avail, rsp_z, err); end
    total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL mid_rdy_mask: got %b want 0000", req_rdy); end
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL mid_first_grant: got %b want 0001", req_rdy); end
    tick();
    req_vld = '0;
    total++; if (mult_avail !== 1'b1 || mult_a !== 64'd20) begin bad++; $display("FAIL mid_first_issue: got %b/%0d want 1/20", mult_avail, mult_a); end
    for (int k = 0; k < 20 && in_flight != 4'd0; k++) tick();
    total++; if (in_flight !== 4'd0 || err !== 1'b0) begin bad++; $display("FAIL mid_drain: got cnt=%0d err=%b want 0,0", in_flight, err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_underflow();
    test_sparse();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
